// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the shared slice-serial add/subtract controller:
//   - controller state encoding
//   - lane width, slice width and the three client operand widths
//   - client index constants
//   - helpers that map a client index to its width / slice count and that
//     sign-extend a lane value from that client's MSB
// ---------------------------------------------------------------------------
package addsub_pkg;

    localparam int DW      = 34;   // lane width (widest client)
    localparam int SLICE_W = 8;    // bits processed per RUN cycle
    localparam int W0      = 32;   // ALU operand width
    localparam int W1      = 33;   // divider operand width
    localparam int W2      = 34;   // multiplier operand width

    localparam int NCLIENT = 3;

    // Internal operand/result registers cover whole slices so that the top
    // slice of a 33/34-bit client can be indexed without range trimming.
    localparam int NSLICE_MAX = (DW + SLICE_W - 1) / SLICE_W;
    localparam int LANE_W     = NSLICE_MAX * SLICE_W;

    localparam logic [1:0] CL_ALU = 2'd0;
    localparam logic [1:0] CL_DIV = 2'd1;
    localparam logic [1:0] CL_MUL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int client_width(input logic [1:0] cl);
        case (cl)
            CL_ALU:  client_width = W0;
            CL_DIV:  client_width = W1;
            CL_MUL:  client_width = W2;
            default: client_width = W2;
        endcase
    endfunction

    // Number of slices needed to reach the client's MSB: ceil(Wi / SLICE_W).
    function automatic logic [2:0] client_nslices(input logic [1:0] cl);
        client_nslices = 3'((client_width(cl) + SLICE_W - 1) / SLICE_W);
    endfunction

    // Replicate bit Wi-1 of v into every bit above it.
    function automatic logic [DW-1:0] sext_dw(input logic [DW-1:0] v,
                                              input logic [1:0]    cl);
        int p;
        p = client_width(cl) - 1;
        for (int i = 0; i < DW; i++) begin
            sext_dw[i] = (i <= p) ? v[i] : v[p];
        end
    endfunction

endpackage

// File: rtl/addsub_slice8.sv
// ---------------------------------------------------------------------------
// addsub_slice8
// Combinational ripple-carry slice, SLICE_W (8) bits wide.
// Ports:
//   a, b  in   operand slices
//   cin   in   carry into bit 0
//   sum   out  a + b + cin, low SLICE_W bits
//   c     out  per-bit carry-out vector; c[j] is the carry out of bit j, so
//              c[SLICE_W-1] is the slice carry-out and c[j-1] is the carry
//              into bit j (used by the controller to derive signed overflow)
// ---------------------------------------------------------------------------
module addsub_slice8
    import addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic [SLICE_W-1:0] c
);

    // cc[j] is the carry into bit j; cc[SLICE_W] is the slice carry-out.
    logic [SLICE_W:0] cc;

    assign cc[0] = cin;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
            assign sum[gi]  = a[gi] ^ b[gi] ^ cc[gi];
            assign cc[gi+1] = (a[gi] & b[gi]) | (a[gi] & cc[gi]) | (b[gi] & cc[gi]);
        end
    endgenerate

    assign c = cc[SLICE_W:1];

endmodule

// File: rtl/addsub_share_ctrl.sv
// ---------------------------------------------------------------------------
// addsub_share_ctrl
// Round-robin controller that time-shares one 8-bit slice adder among three
// clients (0 = 32b ALU, 1 = 33b divider, 2 = 34b multiplier). One operation
// is in flight at a time; it is run slice by slice from bit 0 up to the
// owning client's MSB, then the result is presented until the owner accepts.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_b      synchronous active-low reset
//   req_valid  [3]      per-client request valid
//   req_ready  [3]      one-hot grant, only in IDLE, combinational
//   req_sub    [3]      per-client op select, 1 = A-B, 0 = A+B
//   req_a      [3*DW]   client i operand A at [i*DW +: DW]
//   req_b      [3*DW]   client i operand B, same packing
//   rsp_valid  [3]      one-hot result valid for the owning client
//   rsp_ready  [3]      per-client result accept (only the owner's bit matters)
//   rsp_sum    [DW]     result truncated to Wi, sign-extended to DW
//   rsp_cout   carry out of bit Wi-1 (for subtract, 1 = no borrow)
//   rsp_ovf    signed overflow: carry into bit Wi-1 XOR carry out of it
//   busy       high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module addsub_share_ctrl
    import addsub_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NCLIENT-1:0]    req_valid,
    output logic [NCLIENT-1:0]    req_ready,
    input  logic [NCLIENT-1:0]    req_sub,
    input  logic [NCLIENT*DW-1:0] req_a,
    input  logic [NCLIENT*DW-1:0] req_b,
    output logic [NCLIENT-1:0]    rsp_valid,
    input  logic [NCLIENT-1:0]    rsp_ready,
    output logic [DW-1:0]         rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic                  busy
);

    // ---------------------------------------------------------------- state
    state_t              state_reg;
    logic [1:0]          rr_ptr_reg;
    logic [1:0]          owner_reg;
    logic [LANE_W-1:0]   a_reg;
    logic [LANE_W-1:0]   b_reg;
    logic [LANE_W-1:0]   sum_reg;
    logic                carry_reg;
    logic [2:0]          slice_cnt_reg;
    logic [2:0]          nslices_reg;
    logic [NCLIENT-1:0]  rsp_valid_reg;
    logic [DW-1:0]       rsp_sum_reg;
    logic                rsp_cout_reg;
    logic                rsp_ovf_reg;

    // --------------------------------------------- per-client operand prep
    // Each client's operands are sign-extended from its own MSB across the
    // whole lane so the upper, never-computed slices stay consistent. B is
    // inverted here for subtract; the +1 comes from seeding the carry.
    logic [DW-1:0]     a_dw  [NCLIENT];
    logic [DW-1:0]     b_dw  [NCLIENT];
    logic [LANE_W-1:0] a_ext [NCLIENT];
    logic [LANE_W-1:0] b_ext [NCLIENT];

    generate
        for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_client
            assign a_dw[gi]  = sext_dw(req_a[gi*DW +: DW], 2'(gi));
            assign b_dw[gi]  = sext_dw(req_b[gi*DW +: DW] ^ {DW{req_sub[gi]}}, 2'(gi));
            assign a_ext[gi] = {{(LANE_W-DW){a_dw[gi][DW-1]}}, a_dw[gi]};
            assign b_ext[gi] = {{(LANE_W-DW){b_dw[gi][DW-1]}}, b_dw[gi]};
        end
    endgenerate

    // ------------------------------------------------------------- arbiter
    // Search rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) for the first valid request.
    logic [1:0] winner;
    logic       found;

    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < NCLIENT; k++) begin
            int idx;
            idx = (int'(rr_ptr_reg) + k) % NCLIENT;
            if (!found && req_valid[idx]) begin
                winner = 2'(idx);
                found  = 1'b1;
            end
        end
        req_ready = (state_reg == IDLE && found) ? (NCLIENT'(1) << winner) : '0;
    end

    // ------------------------------------------------------------ datapath
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic [SLICE_W-1:0] slice_c;
    logic [LANE_W-1:0]  sum_next;
    logic [2:0]         msb_bit;
    logic               msb_cin;
    logic               msb_cout;
    logic               last_slice;
    int                 slice_lsb;

    always_comb begin
        slice_lsb = int'(slice_cnt_reg) * SLICE_W;
        slice_a   = a_reg[slice_lsb +: SLICE_W];
        slice_b   = b_reg[slice_lsb +: SLICE_W];
    end

    addsub_slice8 u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_reg),
        .sum (slice_sum),
        .c   (slice_c)
    );

    always_comb begin
        sum_next = sum_reg;
        sum_next[slice_lsb +: SLICE_W] = slice_sum;
        // The last slice always holds bit Wi-1; locate it within the slice.
        msb_bit    = 3'((client_width(owner_reg) - 1) % SLICE_W);
        msb_cout   = slice_c[msb_bit];
        // Carry into the MSB is the slice carry-in when the MSB is bit 0.
        msb_cin    = (msb_bit == 3'd0) ? carry_reg : slice_c[msb_bit - 3'd1];
        last_slice = (slice_cnt_reg == nslices_reg - 3'd1);
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 2'd0;
            owner_reg     <= 2'd0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            slice_cnt_reg <= 3'd0;
            nslices_reg   <= 3'd0;
            rsp_valid_reg <= '0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
            rsp_ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        owner_reg     <= winner;
                        a_reg         <= a_ext[winner];
                        b_reg         <= b_ext[winner];
                        carry_reg     <= req_sub[winner];
                        sum_reg       <= '0;
                        slice_cnt_reg <= 3'd0;
                        nslices_reg   <= client_nslices(winner);
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg       <= sum_next;
                    carry_reg     <= slice_c[SLICE_W-1];
                    slice_cnt_reg <= slice_cnt_reg + 3'd1;
                    if (last_slice) begin
                        rsp_sum_reg   <= sext_dw(sum_next[DW-1:0], owner_reg);
                        rsp_cout_reg  <= msb_cout;
                        rsp_ovf_reg   <= msb_cin ^ msb_cout;
                        rsp_valid_reg <= NCLIENT'(1) << owner_reg;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        rsp_sum_reg   <= '0;
                        rsp_cout_reg  <= 1'b0;
                        rsp_ovf_reg   <= 1'b0;
                        rr_ptr_reg    <= (owner_reg == CL_MUL) ? CL_ALU : owner_reg + 2'd1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign rsp_ovf   = rsp_ovf_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_addsub_share_ctrl
// Directed stimulus with hand-computed results. Expected responses are
// queued when a request is issued; an independent monitor pops and compares
// on every result handshake.
// ---------------------------------------------------------------------------
module tb_addsub_share_ctrl;
    import addsub_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_b = 1'b0;
    logic [NCLIENT-1:0]    req_valid = '0;
    logic [NCLIENT-1:0]    req_ready;
    logic [NCLIENT-1:0]    req_sub = '0;
    logic [NCLIENT*DW-1:0] req_a = '0;
    logic [NCLIENT*DW-1:0] req_b = '0;
    logic [NCLIENT-1:0]    rsp_valid;
    logic [NCLIENT-1:0]    rsp_ready = '0;
    logic [DW-1:0]         rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ovf;
    logic                  busy;

    addsub_share_ctrl dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCLIENT-1:0] oh;
        logic [DW-1:0]      sum;
        logic               cout;
        logic               ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int cl, input logic [DW-1:0] s, input logic c, input logic o);
        exp_t e;
        e.oh   = NCLIENT'(1) << cl;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    // Monitor: compare on every result handshake.
    always @(negedge clk) begin
        if ((rsp_valid & rsp_ready) != '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual_valid=%b required=none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                $display("rsp valid=%b sum=%h cout=%b ovf=%b", rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
                check("rsp_owner", 64'(rsp_valid), 64'(mon_e.oh));
                check("rsp_sum",   64'(rsp_sum),   64'(mon_e.sum));
                check("rsp_cout",  64'(rsp_cout),  64'(mon_e.cout));
                check("rsp_ovf",   64'(rsp_ovf),   64'(mon_e.ovf));
            end
        end
    end

    // Grant checker: any grant must be one-hot, only in IDLE, only to a requester.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            check("grant_onehot", 64'($countones(req_ready)), 64'd1);
            check("grant_in_idle", 64'(busy), 64'd0);
            check("grant_to_valid", 64'((req_ready & ~req_valid) != '0), 64'd0);
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    // One request with rsp_ready held high; checks grant and latency.
    task automatic issue(input int cl, input logic sub, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] esum,
                         input logic ec, input logic eo, input int elat);
        int n;
        int lat;
        $display("issue client=%0d sub=%b a=%h b=%h", cl, sub, a, b);
        req_a[cl*DW +: DW] = a;
        req_b[cl*DW +: DW] = b;
        req_sub[cl]        = sub;
        req_valid[cl]      = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready[cl] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("grant", 64'(req_ready), 64'(NCLIENT'(1) << cl));
        push_exp(cl, esum, ec, eo);
        @(posedge clk); #1;
        // Scramble the inputs after accept; the result must not change.
        req_valid[cl]      = 1'b0;
        req_a[cl*DW +: DW] = ~a;
        req_b[cl*DW +: DW] = ~b;
        req_sub[cl]        = ~sub;
        lat = 0;
        while (rsp_valid[cl] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(elat));
        wait_idle("idle_after_op");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int order [4] = '{0, 1, 2, 0};

    initial begin
        int n;
        int lat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_sum",   64'(rsp_sum),   64'd0);
        check("rst_cout_ovf",  64'({rsp_cout, rsp_ovf}), 64'd0);
        rst_b     = 1'b1;
        rsp_ready = 3'b111;
        @(posedge clk); #1;

        // Single operations
        issue(0, 1'b0, 34'd578, 34'd678, 34'd1256, 1'b0, 1'b0, 4);
        issue(0, 1'b1, 34'd10, 34'd15, 34'h3_FFFF_FFFB, 1'b0, 1'b0, 4);
        issue(1, 1'b0, 34'h0_FFFF_FFFF, 34'd1, 34'h3_0000_0000, 1'b0, 1'b1, 5);
        issue(2, 1'b0, 34'h2_0000_0000, 34'h2_0000_0000, 34'd0, 1'b1, 1'b1, 5);

        // Round-robin with all clients requesting, from reset
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        req_a[0*DW +: DW] = 34'd100;          req_b[0*DW +: DW] = 34'd23;
        req_a[1*DW +: DW] = 34'd5;            req_b[1*DW +: DW] = 34'd7;
        req_a[2*DW +: DW] = 34'h1_FFFF_FFFF;  req_b[2*DW +: DW] = 34'h1_FFFF_FFFF;
        req_sub = 3'b010;
        push_exp(0, 34'd123, 1'b0, 1'b0);
        push_exp(1, 34'h3_FFFF_FFFE, 1'b0, 1'b0);
        push_exp(2, 34'h3_FFFF_FFFE, 1'b0, 1'b1);
        push_exp(0, 34'd123, 1'b0, 1'b0);
        req_valid = 3'b111;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == '0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            $display("grant %0d -> %b", g, req_ready);
            check("rr_order", 64'(req_ready), 64'(NCLIENT'(1) << order[g]));
            @(posedge clk); #1;
        end
        req_valid = '0;
        req_sub   = '0;
        wait_idle("idle_after_rr");

        // Client 2 result held while owner stalls; others ignored meanwhile
        rsp_ready = 3'b011;
        req_a[2*DW +: DW] = 34'd1000;
        req_b[2*DW +: DW] = 34'd1;
        req_sub[2]   = 1'b1;
        req_valid[2] = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready[2] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_grant", 64'(req_ready), 64'b100);
        push_exp(2, 34'd999, 1'b1, 1'b0);
        @(posedge clk); #1;
        req_valid = 3'b011;
        lat = 0;
        while (rsp_valid[2] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stall_latency", 64'(lat), 64'd5);
        repeat (3) begin
            @(negedge clk);
            check("hold_sum",   64'(rsp_sum),   64'd999);
            check("hold_valid", 64'(rsp_valid), 64'b100);
            check("hold_busy",  64'(busy),      64'd1);
            check("hold_noreq", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        req_sub   = '0;
        rsp_ready = 3'b111;
        wait_idle("idle_after_stall");

        // Client 0 carry-out with garbage above bit 31 (leaves rr_ptr = 1)
        issue(0, 1'b0, 34'h2_FFFF_FFFF, 34'h3_0000_0001, 34'd0, 1'b1, 1'b0, 4);

        // Reset during the second RUN cycle: op is dropped, rr_ptr cleared
        req_a[2*DW +: DW] = 34'd5;
        req_b[2*DW +: DW] = 34'd6;
        req_valid[2] = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready[2] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_grant", 64'(req_ready), 64'b100);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd0);
        rst_b = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        req_valid = 3'b111;
        @(negedge clk);
        check("rr_after_reset", 64'(req_ready), 64'b001);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
